// File: rtl/lc_ctrl_state_pkg.sv
// Lifecycle controller shared definitions.
// Holds the 2-bit symbols that build lifecycle state encodings, the lifecycle
// state enum, the controller FSM enum, the response code enum and the
// encoding validity helper.
package lc_ctrl_state_pkg;

    localparam logic [1:0] B0 = 2'b01;
    localparam logic [1:0] B1 = 2'b10;

    typedef enum logic [3:0] {
        LcStRaw   = {B0, B0},  // 4'h5
        LcStTest  = {B0, B1},  // 4'h6
        LcStScrap = {B1, B0},  // 4'h9
        LcStProd  = {B1, B1}   // 4'hA
    } lc_state_e;

    typedef enum logic [2:0] {
        LcFsmInit,
        LcFsmIdle,
        LcFsmCheck,
        LcFsmProgram,
        LcFsmResp,
        LcFsmEscalated
    } lc_fsm_e;

    typedef enum logic [1:0] {
        LcRespOk      = 2'd0,
        LcRespIllegal = 2'd1,
        LcRespTimeout = 2'd2,
        LcRespProgErr = 2'd3
    } lc_resp_e;

    function automatic logic lc_state_valid(logic [3:0] st);
        return st inside {LcStRaw, LcStTest, LcStProd, LcStScrap};
    endfunction

endpackage

// File: rtl/lc_state_reg.sv
// Lifecycle state register: 4-bit flop with load enable.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (loads ResetValue)
//   en_i         : load enable
//   d_i          : next state value
//   q_o          : stored state value
module lc_state_reg #(
    parameter logic [3:0] ResetValue = 4'h9
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= ResetValue;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/lc_ctrl_fsm.sv
// Lifecycle transition controller.
// Loads the lifecycle state once after reset, checks transition requests
// against the legality table and sequences legal ones through the NVM
// programming handshake. Escalation forces Scrap and parks the FSM for good.
//
// Optional feature macro: LC_CTRL_PROG_TIMEOUT_EN adds a programming timeout
// (response code 2) after TimeoutCycles cycles in Program without an ack.
//
// Handshakes: a request transfers on a cycle with req_valid_i && req_ready_o;
// prog_req_o/prog_state_o stay stable until the cycle prog_ack_i is high,
// which completes the programming operation (prog_err_i is only meaningful
// alongside prog_ack_i); resp_valid_o is a one-cycle pulse with resp_err_o.
//
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   init_valid_i/state_i : initial state from NVM (sampled in Init only)
//   req_valid_i/ready_o  : transition request handshake, req_target_i target
//   esc_i                : escalation, forces Scrap
//   prog_req_o/state_o   : programming request and value to program
//   prog_ack_i/err_i     : programming completion and error flag
//   resp_valid_o/err_o   : response pulse and code (0 OK,1 ILLEGAL,2 TIMEOUT,3 PROG_ERR)
//   state_o              : current lifecycle state
//   state_invalid_o      : sticky flag, loaded encoding was undefined
//   dbgFsm_o             : current controller FSM state
module lc_ctrl_fsm
    import lc_ctrl_state_pkg::*;
#(
    parameter logic [3:0] ResetValue    = 4'(LcStScrap),
    parameter int         TimeoutCycles = 255,
    parameter int         TimeoutW      = $clog2(TimeoutCycles + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       init_valid_i,
    input  logic [3:0] init_state_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_target_i,
    input  logic       esc_i,
    output logic       prog_req_o,
    output logic [3:0] prog_state_o,
    input  logic       prog_ack_i,
    input  logic       prog_err_i,
    output logic       resp_valid_o,
    output logic [1:0] resp_err_o,
    output logic [3:0] state_o,
    output logic       state_invalid_o,
    output lc_fsm_e    dbgFsm_o
);

    lc_fsm_e    fsmQ, fsmNext;
    logic [3:0] targetQ;
    logic       targetLoad;
    logic       stateLoad;
    logic [3:0] stateD;
    logic       invalidSet;
    logic       respLoad;
    lc_resp_e   respCode;
    logic       timeoutHit;

    function automatic logic transLegal(logic [3:0] cur, logic [3:0] tgt);
        case (cur)
            LcStRaw:  return tgt == LcStTest || tgt == LcStProd || tgt == LcStScrap;
            LcStTest: return tgt == LcStProd || tgt == LcStScrap;
            LcStProd: return tgt == LcStScrap;
            default:  return 1'b0;
        endcase
    endfunction

    lc_state_reg #(
        .ResetValue(ResetValue)
    ) u_state_reg (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (stateLoad),
        .d_i  (stateD),
        .q_o  (state_o)
    );

`ifdef LC_CTRL_PROG_TIMEOUT_EN
    logic [TimeoutW-1:0] timeoutCnt;

    // Held at zero outside Program, so it starts from zero on every entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeoutCnt <= '0;
        end else if (fsmQ == LcFsmProgram) begin
            timeoutCnt <= timeoutCnt + 1'b1;
        end else begin
            timeoutCnt <= '0;
        end
    end

    // Last Program cycle is the one where the count equals TimeoutCycles-1,
    // so prog_req_o is high for exactly TimeoutCycles cycles.
    assign timeoutHit = (fsmQ == LcFsmProgram) && (timeoutCnt == TimeoutW'(TimeoutCycles - 1));
`else
    logic [TimeoutW-1:0] unusedTimeoutCfg;
    assign unusedTimeoutCfg = TimeoutW'(TimeoutCycles);
    assign timeoutHit       = 1'b0;
`endif

    always_comb begin
        fsmNext    = fsmQ;
        targetLoad = 1'b0;
        stateLoad  = 1'b0;
        stateD     = state_o;
        invalidSet = 1'b0;
        respLoad   = 1'b0;
        respCode   = LcRespOk;
        if (esc_i) begin
            // Escalation beats everything, including a same-cycle ack.
            fsmNext   = LcFsmEscalated;
            stateLoad = 1'b1;
            stateD    = LcStScrap;
        end else begin
            case (fsmQ)
                LcFsmInit: begin
                    if (init_valid_i) begin
                        stateLoad = 1'b1;
                        fsmNext   = LcFsmIdle;
                        if (lc_state_valid(init_state_i)) begin
                            stateD = init_state_i;
                        end else begin
                            stateD     = LcStScrap;
                            invalidSet = 1'b1;
                        end
                    end
                end
                LcFsmIdle: begin
                    if (req_valid_i) begin
                        targetLoad = 1'b1;
                        fsmNext    = LcFsmCheck;
                    end
                end
                LcFsmCheck: begin
                    if (transLegal(state_o, targetQ)) begin
                        fsmNext = LcFsmProgram;
                    end else begin
                        fsmNext  = LcFsmResp;
                        respLoad = 1'b1;
                        respCode = LcRespIllegal;
                    end
                end
                LcFsmProgram: begin
                    if (prog_ack_i) begin
                        fsmNext  = LcFsmResp;
                        respLoad = 1'b1;
                        if (prog_err_i) begin
                            respCode = LcRespProgErr;
                        end else begin
                            respCode  = LcRespOk;
                            stateLoad = 1'b1;
                            stateD    = targetQ;
                        end
                    end else if (timeoutHit) begin
                        fsmNext  = LcFsmResp;
                        respLoad = 1'b1;
                        respCode = LcRespTimeout;
                    end
                end
                LcFsmResp: begin
                    fsmNext = LcFsmIdle;
                end
                LcFsmEscalated: begin
                    fsmNext = LcFsmEscalated;
                end
                default: begin
                    fsmNext = LcFsmEscalated;
                end
            endcase
        end
    end

    // Handshake outputs are registered decodes of the next FSM state, so they
    // line up with the FSM register and clear asynchronously on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsmQ            <= LcFsmInit;
            targetQ         <= '0;
            state_invalid_o <= 1'b0;
            req_ready_o     <= 1'b0;
            prog_req_o      <= 1'b0;
            resp_valid_o    <= 1'b0;
            resp_err_o      <= '0;
        end else begin
            fsmQ         <= fsmNext;
            req_ready_o  <= (fsmNext == LcFsmIdle);
            prog_req_o   <= (fsmNext == LcFsmProgram);
            resp_valid_o <= (fsmNext == LcFsmResp);
            if (targetLoad) begin
                targetQ <= req_target_i;
            end
            if (invalidSet) begin
                state_invalid_o <= 1'b1;
            end
            if (respLoad) begin
                resp_err_o <= respCode;
            end
        end
    end

    assign prog_state_o = targetQ;
    assign dbgFsm_o     = fsmQ;

endmodule

// File: tb/tb_lc_ctrl_fsm.sv
// Directed testbench for lc_ctrl_fsm.
module tb_lc_ctrl_fsm;
    import lc_ctrl_state_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_valid = 1'b0;
    logic [3:0] init_state = '0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_target = '0;
    logic       esc = 1'b0;
    logic       prog_req;
    logic [3:0] prog_state;
    logic       prog_ack = 1'b0;
    logic       prog_err = 1'b0;
    logic       resp_valid;
    logic [1:0] resp_err;
    logic [3:0] state;
    logic       state_invalid;
    lc_fsm_e    dbg_fsm;

    int errors = 0;
    int checks = 0;
    int resp_count = 0;
    logic [1:0] exp_q[$];

    lc_ctrl_fsm #(
        .TimeoutCycles(4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .init_valid_i   (init_valid),
        .init_state_i   (init_state),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_target_i   (req_target),
        .esc_i          (esc),
        .prog_req_o     (prog_req),
        .prog_state_o   (prog_state),
        .prog_ack_i     (prog_ack),
        .prog_err_i     (prog_err),
        .resp_valid_o   (resp_valid),
        .resp_err_o     (resp_err),
        .state_o        (state),
        .state_invalid_o(state_invalid),
        .dbgFsm_o       (dbg_fsm)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // scoreboard: every response pulse must match the oldest expected code
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            resp_count++;
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_err), 32'hFF);
            end else begin
                check("resp_code_sb", 32'(resp_err), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        init_valid = 1'b0;
        req_valid  = 1'b0;
        esc        = 1'b0;
        prog_ack   = 1'b0;
        prog_err   = 1'b0;
        tick();
        check("rst_state", 32'(state), 32'h9);
        check("rst_invalid", 32'(state_invalid), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_prog_req", 32'(prog_req), 0);
        check("rst_prog_state", 32'(prog_state), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("rst_fsm", 32'(dbg_fsm), 32'(LcFsmInit));
        rst = 1'b0;
    endtask

    task automatic init_to(input logic [3:0] v);
        do_reset();
        init_valid = 1'b1;
        init_state = v;
        tick();
        init_valid = 1'b0;
    endtask

    task automatic send_req(input logic [3:0] tgt);
        req_valid  = 1'b1;
        req_target = tgt;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int n;

        // Raw init
        init_to(4'h5);
        check("init_raw_state", 32'(state), 32'h5);
        check("init_raw_invalid", 32'(state_invalid), 0);
        check("init_raw_ready", 32'(req_ready), 1);

        // invalid init loads Scrap; any request is then illegal
        init_to(4'h3);
        check("init_bad_state", 32'(state), 32'h9);
        check("init_bad_invalid", 32'(state_invalid), 1);
        exp_q.push_back(2'd1);
        send_req(4'hA);
        check("scrap_req_check_fsm", 32'(dbg_fsm), 32'(LcFsmCheck));
        tick();
        check("scrap_req_resp_valid", 32'(resp_valid), 1);
        check("scrap_req_code", 32'(resp_err), 1);
        tick();
        check("scrap_req_ready_back", 32'(req_ready), 1);
        check("scrap_req_pulse_end", 32'(resp_valid), 0);
        check("scrap_invalid_sticky", 32'(state_invalid), 1);

        // Raw -> Prod, ack three cycles after prog_req rises
        init_to(4'h5);
        send_req(4'hA);
        check("rp_no_prog_in_check", 32'(prog_req), 0);
        tick();
        check("rp_prog_req_rise", 32'(prog_req), 1);
        check("rp_prog_state0", 32'(prog_state), 32'hA);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rp_prog_req_hold", 32'(prog_req), 1);
            check("rp_prog_state_hold", 32'(prog_state), 32'hA);
            check("rp_state_unchanged", 32'(state), 32'h5);
        end
        prog_ack = 1'b1;
        exp_q.push_back(2'd0);
        tick();
        prog_ack = 1'b0;
        check("rp_state_new", 32'(state), 32'hA);
        check("rp_resp_valid", 32'(resp_valid), 1);
        check("rp_resp_code", 32'(resp_err), 0);
        check("rp_prog_req_drop", 32'(prog_req), 0);
        tick();
        check("rp_ready_back", 32'(req_ready), 1);

        // Prod -> Test illegal, no programming
        init_to(4'hA);
        exp_q.push_back(2'd1);
        send_req(4'h6);
        check("pt_no_prog_check", 32'(prog_req), 0);
        tick();
        check("pt_no_prog_resp", 32'(prog_req), 0);
        check("pt_resp_valid", 32'(resp_valid), 1);
        check("pt_resp_code", 32'(resp_err), 1);
        tick();

        // Prod -> Scrap with programming error
        send_req(4'h9);
        tick();
        check("pe_prog_req", 32'(prog_req), 1);
        prog_ack = 1'b1;
        prog_err = 1'b1;
        exp_q.push_back(2'd3);
        tick();
        prog_ack = 1'b0;
        prog_err = 1'b0;
        check("pe_resp_valid", 32'(resp_valid), 1);
        check("pe_resp_code", 32'(resp_err), 3);
        check("pe_state_kept", 32'(state), 32'hA);
        tick();

        // escalation in Program together with ack
        init_to(4'h5);
        send_req(4'h6);
        tick();
        check("esc_in_program", 32'(dbg_fsm), 32'(LcFsmProgram));
        esc      = 1'b1;
        prog_ack = 1'b1;
        tick();
        esc      = 1'b0;
        prog_ack = 1'b0;
        check("esc_state", 32'(state), 32'h9);
        check("esc_fsm", 32'(dbg_fsm), 32'(LcFsmEscalated));
        check("esc_resp_valid", 32'(resp_valid), 0);
        req_valid  = 1'b1;
        req_target = 4'hA;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("esc_ready_low", 32'(req_ready), 0);
            check("esc_prog_low", 32'(prog_req), 0);
            check("esc_fsm_stuck", 32'(dbg_fsm), 32'(LcFsmEscalated));
            check("esc_state_hold", 32'(state), 32'h9);
        end
        req_valid = 1'b0;

        // Program without ack
        init_to(4'h5);
        send_req(4'hA);
        tick();
        check("to_prog_req", 32'(prog_req), 1);
`ifdef LC_CTRL_PROG_TIMEOUT_EN
        exp_q.push_back(2'd2);
        n = 0;
        while (prog_req && n < 20) begin
            n++;
            tick();
        end
        check("to_prog_cycles", 32'(n), 4);
        check("to_resp_valid", 32'(resp_valid), 1);
        check("to_resp_code", 32'(resp_err), 2);
        check("to_state_kept", 32'(state), 32'h5);
        tick();
`else
        n = resp_count;
        repeat (1000) tick();
        check("noto_no_resp", 32'(resp_count - n), 0);
        check("noto_prog_req", 32'(prog_req), 1);
        check("noto_state_kept", 32'(state), 32'h5);
        // reset mid-Program takes effect without a clock edge
        rst = 1'b1;
        #1;
        check("rst_mid_prog_req", 32'(prog_req), 0);
        check("rst_mid_state", 32'(state), 32'h9);
        do_reset();
`endif

        check("sb_pending", 32'(exp_q.size()), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc_ctrl_fsm.md
# lc_ctrl_fsm

Lifecycle transition controller that owns the 4-bit lifecycle state register, built from two 2-bit symbols `B0=2'b01` and `B1=2'b10`. It loads the initial state once after reset and arbitrates transition requests against a fixed legality table. Each legal transition is sequenced through a request/acknowledge handshake with the non-volatile programming engine. The block sits between the lifecycle request front-end and the NVM programming port, and drives the decoded state to downstream consumers.

## Interface
- `ResetValue`, `4'(LcStScrap)`: value of the state register while reset is asserted.
- `TimeoutCycles`, 255: maximum number of cycles in `Program` before a timeout is raised.
- `TimeoutW`, `$clog2(TimeoutCycles+1)`: width of the timeout counter.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous assert, active-high.
- `init_valid_i` in 1: initial state from NVM is valid.
- `init_state_i` in 4: initial state encoding.
- `req_valid_i` in 1: transition request.
- `req_ready_o` out 1: request accepted.
- `req_target_i` in 4: requested target state.
- `esc_i` in 1: escalation; forces Scrap.
- `prog_req_o` out 1: programming request.
- `prog_state_o` out 4: state value being programmed.
- `prog_ack_i` in 1: programming done.
- `prog_err_i` in 1: programming failed; qualified by `prog_ack_i`.
- `resp_valid_o` out 1: single-cycle response pulse.
- `resp_err_o` out 2: response code. 0 OK, 1 ILLEGAL, 2 TIMEOUT, 3 PROG_ERR.
- `state_o` out 4: current lifecycle state.
- `state_invalid_o` out 1: the loaded or stored encoding was not a defined state.

## Operation
- State encodings:
  - `LcStRaw={B0,B0}=4'h5`
  - `LcStTest={B0,B1}=4'h6`
  - `LcStProd={B1,B1}=4'hA`
  - `LcStScrap={B1,B0}=4'h9`
  - Every other value is invalid.
- FSM states: `Init`, `Idle`, `Check`, `Program`, `Resp`, `Escalated`.
- `Init`:
  - Waits for `init_valid_i`.
  - A valid encoding loads the state register.
  - An invalid encoding loads `LcStScrap` and sets `state_invalid_o` (sticky until reset).
  - Goes to `Idle`.
- `Idle`:
  - `req_ready_o=1`.
  - On `req_valid_i`, latches `req_target_i` and goes to `Check`.
- `Check` applies the legality table:
  - Legal: Raw→Test, Raw→Prod, Test→Prod, {Raw,Test,Prod}→Scrap.
  - Everything else is ILLEGAL, including same-state requests, any transition out of Scrap, and invalid targets.
  - Legal → `Program`. Illegal → `Resp` with code 1.
- `Program`:
  - `prog_req_o=1` and `prog_state_o` equals the latched target, both held stable until the cycle `prog_ack_i=1`.
  - Ack without error: the state register takes the target value; code 0.
  - Ack with `prog_err_i`: the state register is unchanged; code 3.
  - Either case goes to `Resp`.
- `Resp`: `resp_valid_o=1` for exactly one cycle, then `Idle`.
- `Escalated`:
  - Terminal; only reset leaves it.
  - State register holds `LcStScrap`.
  - `req_ready_o=0`, `prog_req_o=0`.
- `esc_i` priority:
  - `esc_i` in any FSM state has priority over everything else.
  - Next cycle: state register = `LcStScrap`, FSM = `Escalated`.
  - In-flight requests get no response.
  - `prog_ack_i` arriving in the same cycle as `esc_i` is ignored.

## Timing
- Reset values:
  - `state_o=ResetValue`
  - FSM = `Init`
  - `state_invalid_o=0`
  - `req_ready_o=0`, `prog_req_o=0`, `prog_state_o=0`
  - `resp_valid_o=0`, `resp_err_o=0`
- `req_ready_o` and `prog_req_o` are registered decodes of the FSM state.
- Latency, request accept to `prog_req_o` rising: 2 cycles (`Check`, then `Program`).
- `prog_ack_i` at cycle N:
  - `state_o` updates at N+1.
  - `resp_valid_o` is high at N+1.
  - `req_ready_o` is high again at N+2.
- Illegal request accepted at cycle N: `resp_valid_o` is high at N+2 with code 1.
- `init_valid_i` is ignored outside `Init`. `prog_ack_i` is ignored outside `Program`.
- Reset asserted mid-`Program`:
  - `prog_req_o` drops immediately.
  - The state register returns to `ResetValue`.

## Configuration
- Macro: `LC_CTRL_PROG_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to `Program` and increments every cycle there.
  - When the count reaches `TimeoutCycles` without ack, `prog_req_o` drops, the state is unchanged, and the FSM goes to `Resp` with code 2.
  - An ack that arrives in the same cycle as the terminal count wins.
- Undefined:
  - No counter exists, `Program` waits indefinitely, and code 2 is never produced.

## Structure
- `lc_ctrl_state_pkg` holds:
  - `B0`, `B1`
  - `lc_state_e`, including Raw/Test/Prod/Scrap
  - the FSM enum `lc_fsm_e`
  - the response enum `lc_resp_e`
  - a `lc_state_valid()` function
- Sub-module `lc_state_reg`: 4-bit asynchronous-reset flop with parameter `ResetValue` and load enable. It is instantiated with `.ResetValue(ResetValue)`.

## Test plan
- Reset, then `init_state_i=4'h5` with `init_valid_i` → `state_o=4'h5`, `state_invalid_o=0`, `req_ready_o=1`.
- Init `4'h3` → `state_o=4'h9`, `state_invalid_o=1`. A subsequent request for `4'hA` → response code 1.
- State Raw, request target `4'hA`, ack 3 cycles after `prog_req_o` rises → `prog_state_o=4'hA` throughout, `state_o=4'hA` and `resp_valid_o` high with code 0 on the cycle after ack.
- State Prod, request target `4'h6` → response code 1 two cycles after accept, `prog_req_o` never asserted. A second test: ack with `prog_err_i=1` → code 3, state unchanged.
- `esc_i` pulsed in `Program` in the same cycle as `prog_ack_i` → `state_o=4'h9`, FSM `Escalated`, no `resp_valid_o`, `req_ready_o=0` until reset.
- With `LC_CTRL_PROG_TIMEOUT_EN` and `TimeoutCycles=4`, no ack → `prog_req_o` drops after 4 cycles, code 2, state unchanged. Without the macro, no response after 1000 cycles.
